// File: rtl/spi_xip_arb.sv
// spi_xip_arb: shares one SPI-master register port between a CPU register
// interface and an execute-in-place (XIP) flash read sequencer.
// Build option: define SPI_XIP_BSWAP_EN to byte-swap xip_rdata (cpu_rdata is
// never swapped).
module spi_xip_arb #(
    parameter logic [31:0] DIVIDER_VAL = 32'h1,
    parameter logic [31:0] SS_VAL      = 32'h1,
    parameter int unsigned POLL_MAX    = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        xip_req,
    input  logic [23:0] xip_addr,
    output logic        xip_ack,
    output logic        xip_err,
    output logic [31:0] xip_rdata,
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_adr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_sel,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic [4:0]  m_adr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_sel,
    output logic        m_we,
    output logic        m_stb,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    localparam int unsigned PCW = $clog2(POLL_MAX + 1);

    localparam logic [4:0]  ADR_RX0  = 5'h00;
    localparam logic [4:0]  ADR_TX1  = 5'h04;
    localparam logic [4:0]  ADR_CTRL = 5'h10;
    localparam logic [4:0]  ADR_DIV  = 5'h14;
    localparam logic [4:0]  ADR_SS   = 5'h18;
    localparam logic [7:0]  CMD_READ = 8'h03;
    localparam logic [31:0] CTRL_GO  = 32'h0000_0140;

    typedef enum logic [3:0] {
        IDLE,
        CPU,
        CMD,
        DIV,
        SS,
        GO,
        POLL,
        READ,
        CLRSS,
        DONE
    } state_t;

    state_t         r_state,     w_state_nxt;
    logic           r_m_stb,     w_m_stb_nxt;
    logic           r_m_we,      w_m_we_nxt;
    logic [4:0]     r_m_adr,     w_m_adr_nxt;
    logic [31:0]    r_m_wdata,   w_m_wdata_nxt;
    logic [3:0]     r_m_sel,     w_m_sel_nxt;
    logic           r_xip_ack,   w_xip_ack_nxt;
    logic           r_xip_err,   w_xip_err_nxt;
    logic [31:0]    r_xip_rdata, w_xip_rdata_nxt;
    logic           r_cpu_ack,   w_cpu_ack_nxt;
    logic [31:0]    r_cpu_rdata, w_cpu_rdata_nxt;
    logic [23:0]    r_addr,      w_addr_nxt;
    logic [31:0]    r_rx,        w_rx_nxt;
    logic           r_err,       w_err_nxt;
    logic [PCW-1:0] r_poll_cnt,  w_poll_cnt_nxt;
    logic           r_last_xip,  w_last_xip_nxt;

    logic           w_cpu_req;
    logic           w_grant_xip;
    logic           w_grant_cpu;
    logic [4:0]     w_acc_adr;
    logic           w_acc_we;
    logic [31:0]    w_acc_wdata;
    logic [31:0]    w_rx_out;

    assign m_stb     = r_m_stb;
    assign m_we      = r_m_we;
    assign m_adr     = r_m_adr;
    assign m_wdata   = r_m_wdata;
    assign m_sel     = r_m_sel;
    assign xip_ack   = r_xip_ack;
    assign xip_err   = r_xip_err;
    assign xip_rdata = r_xip_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;

    // The CPU holds cpu_stb through the cycle cpu_ack is visible; mask it so
    // the finished access is not granted a second time.
    assign w_cpu_req   = cpu_stb & ~r_cpu_ack;
    assign w_grant_xip = xip_req & (~w_cpu_req | ~r_last_xip);
    assign w_grant_cpu = w_cpu_req & ~w_grant_xip;

`ifdef SPI_XIP_BSWAP_EN
    assign w_rx_out = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
`else
    assign w_rx_out = r_rx;
`endif

    // Register-port access performed by each XIP sequence step.
    always_comb begin
        w_acc_adr   = ADR_TX1;
        w_acc_we    = 1'b1;
        w_acc_wdata = {CMD_READ, r_addr};
        case (r_state)
            DIV: begin
                w_acc_adr   = ADR_DIV;
                w_acc_wdata = DIVIDER_VAL;
            end
            SS: begin
                w_acc_adr   = ADR_SS;
                w_acc_wdata = SS_VAL;
            end
            GO: begin
                w_acc_adr   = ADR_CTRL;
                w_acc_wdata = CTRL_GO;
            end
            POLL: begin
                w_acc_adr   = ADR_CTRL;
                w_acc_we    = 1'b0;
                w_acc_wdata = 32'h0;
            end
            READ: begin
                w_acc_adr   = ADR_RX0;
                w_acc_we    = 1'b0;
                w_acc_wdata = 32'h0;
            end
            CLRSS: begin
                w_acc_adr   = ADR_SS;
                w_acc_wdata = 32'h0;
            end
            default: begin
                w_acc_adr   = ADR_TX1;
                w_acc_we    = 1'b1;
                w_acc_wdata = {CMD_READ, r_addr};
            end
        endcase
    end

    // Next-state, bus and response logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_m_stb_nxt     = r_m_stb;
        w_m_we_nxt      = r_m_we;
        w_m_adr_nxt     = r_m_adr;
        w_m_wdata_nxt   = r_m_wdata;
        w_m_sel_nxt     = r_m_sel;
        w_xip_ack_nxt   = 1'b0;
        w_xip_err_nxt   = 1'b0;
        w_xip_rdata_nxt = r_xip_rdata;
        w_cpu_ack_nxt   = 1'b0;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_addr_nxt      = r_addr;
        w_rx_nxt        = r_rx;
        w_err_nxt       = r_err;
        w_poll_cnt_nxt  = r_poll_cnt;
        w_last_xip_nxt  = r_last_xip;

        case (r_state)
            IDLE: begin
                if (w_grant_xip) begin
                    // Grant launches the TX1 command write immediately.
                    w_state_nxt    = CMD;
                    w_addr_nxt     = xip_addr;
                    w_rx_nxt       = 32'h0;
                    w_err_nxt      = 1'b0;
                    w_poll_cnt_nxt = '0;
                    w_last_xip_nxt = 1'b1;
                    w_m_stb_nxt    = 1'b1;
                    w_m_we_nxt     = 1'b1;
                    w_m_adr_nxt    = ADR_TX1;
                    w_m_wdata_nxt  = {CMD_READ, xip_addr};
                    w_m_sel_nxt    = 4'hF;
                end else if (w_grant_cpu) begin
                    w_state_nxt    = CPU;
                    w_last_xip_nxt = 1'b0;
                    w_m_stb_nxt    = 1'b1;
                    w_m_we_nxt     = cpu_we;
                    w_m_adr_nxt    = cpu_adr;
                    w_m_wdata_nxt  = cpu_wdata;
                    w_m_sel_nxt    = cpu_sel;
                end
            end

            CPU: begin
                if (r_m_stb && m_ack) begin
                    w_m_stb_nxt     = 1'b0;
                    w_m_we_nxt      = 1'b0;
                    w_cpu_ack_nxt   = 1'b1;
                    w_cpu_rdata_nxt = m_rdata;
                    w_state_nxt     = IDLE;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                // XIP steps: issue after a strobe-low cycle, advance on ack.
                if (!r_m_stb) begin
                    w_m_stb_nxt   = 1'b1;
                    w_m_we_nxt    = w_acc_we;
                    w_m_adr_nxt   = w_acc_adr;
                    w_m_wdata_nxt = w_acc_wdata;
                    w_m_sel_nxt   = 4'hF;
                end else if (m_ack) begin
                    w_m_stb_nxt = 1'b0;
                    w_m_we_nxt  = 1'b0;
                    case (r_state)
                        CMD:  w_state_nxt = DIV;
                        DIV:  w_state_nxt = SS;
                        SS:   w_state_nxt = GO;
                        GO:   w_state_nxt = POLL;
                        POLL: begin
                            if (!m_rdata[8]) begin
                                w_state_nxt = READ;
                            end else if (r_poll_cnt == PCW'(POLL_MAX - 1)) begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = CLRSS;
                            end else begin
                                w_poll_cnt_nxt = r_poll_cnt + PCW'(1);
                            end
                        end
                        READ: begin
                            w_rx_nxt    = m_rdata;
                            w_state_nxt = CLRSS;
                        end
                        CLRSS: begin
                            w_state_nxt     = DONE;
                            w_xip_ack_nxt   = 1'b1;
                            w_xip_err_nxt   = r_err;
                            w_xip_rdata_nxt = w_rx_out;
                        end
                        default: w_state_nxt = IDLE;
                    endcase
                end
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_m_stb     <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_adr     <= 5'h0;
            r_m_wdata   <= 32'h0;
            r_m_sel     <= 4'h0;
            r_xip_ack   <= 1'b0;
            r_xip_err   <= 1'b0;
            r_xip_rdata <= 32'h0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= 32'h0;
            r_addr      <= 24'h0;
            r_rx        <= 32'h0;
            r_err       <= 1'b0;
            r_poll_cnt  <= '0;
            r_last_xip  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_m_stb     <= w_m_stb_nxt;
            r_m_we      <= w_m_we_nxt;
            r_m_adr     <= w_m_adr_nxt;
            r_m_wdata   <= w_m_wdata_nxt;
            r_m_sel     <= w_m_sel_nxt;
            r_xip_ack   <= w_xip_ack_nxt;
            r_xip_err   <= w_xip_err_nxt;
            r_xip_rdata <= w_xip_rdata_nxt;
            r_cpu_ack   <= w_cpu_ack_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_addr      <= w_addr_nxt;
            r_rx        <= w_rx_nxt;
            r_err       <= w_err_nxt;
            r_poll_cnt  <= w_poll_cnt_nxt;
            r_last_xip  <= w_last_xip_nxt;
        end
    end

endmodule

// File: tb/tb_spi_xip_arb.sv
// Testbench for spi_xip_arb: random SPI-master slave model plus a
// transaction-level expectation of every register access the block makes.
`timescale 1ns/1ps
module tb_spi_xip_arb;

    localparam int          POLL_MAX = 4;
    localparam logic [31:0] DIV_V    = 32'h0000_0001;
    localparam logic [31:0] SS_V     = 32'h0000_0001;

    typedef struct packed {
        logic        we;
        logic [4:0]  adr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } acc_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        xip_req = 1'b0;
    logic [23:0] xip_addr = 24'h0;
    logic        xip_ack;
    logic        xip_err;
    logic [31:0] xip_rdata;
    logic        cpu_stb = 1'b0;
    logic        cpu_we = 1'b0;
    logic [4:0]  cpu_adr = 5'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic [3:0]  cpu_sel = 4'h0;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic [4:0]  m_adr;
    logic [31:0] m_wdata;
    logic [3:0]  m_sel;
    logic        m_we;
    logic        m_stb;
    logic [31:0] m_rdata = 32'h0;
    logic        m_ack = 1'b0;

    spi_xip_arb #(
        .DIVIDER_VAL(DIV_V),
        .SS_VAL     (SS_V),
        .POLL_MAX   (POLL_MAX)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .xip_req  (xip_req),
        .xip_addr (xip_addr),
        .xip_ack  (xip_ack),
        .xip_err  (xip_err),
        .xip_rdata(xip_rdata),
        .cpu_stb  (cpu_stb),
        .cpu_we   (cpu_we),
        .cpu_adr  (cpu_adr),
        .cpu_wdata(cpu_wdata),
        .cpu_sel  (cpu_sel),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .m_adr    (m_adr),
        .m_wdata  (m_wdata),
        .m_sel    (m_sel),
        .m_we     (m_we),
        .m_stb    (m_stb),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass = 0;
    acc_t        log_q[$];
    acc_t        exp_q[$];
    logic [31:0] regs[32];
    int          lat_max = 0;
    int          poll_left = 0;
    logic [31:0] rx_val = 32'h0;
    logic        s_busy = 1'b0;
    int          s_dly = 0;

    // Slave model: random ack latency, logs every completed access.
    always @(negedge clock) begin
        acc_t e;
        if (reset) begin
            m_ack  = 1'b0;
            s_busy = 1'b0;
        end else if (m_ack) begin
            m_ack  = 1'b0;
            s_busy = 1'b0;
        end else if (m_stb) begin
            if (!s_busy) begin
                s_busy = 1'b1;
                s_dly  = int'($urandom_range(lat_max, 0));
            end
            if (s_dly == 0) begin
                m_ack = 1'b1;
                if (!m_we && m_adr == 5'h10) begin
                    if (poll_left > 0) begin
                        m_rdata   = 32'h0000_0140;
                        poll_left = poll_left - 1;
                    end else begin
                        m_rdata = 32'h0000_0040;
                    end
                end else if (!m_we && m_adr == 5'h00) begin
                    m_rdata = rx_val;
                end else begin
                    m_rdata = regs[m_adr];
                end
                e.we    = m_we;
                e.adr   = m_adr;
                e.wdata = m_we ? m_wdata : 32'h0;
                e.sel   = m_we ? m_sel : 4'h0;
                log_q.push_back(e);
            end else begin
                s_dly = s_dly - 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    function automatic void push_acc(input logic we, input logic [4:0] adr,
                                     input logic [31:0] wd, input logic [3:0] sel);
        acc_t e;
        e.we    = we;
        e.adr   = adr;
        e.wdata = we ? wd : 32'h0;
        e.sel   = we ? sel : 4'h0;
        exp_q.push_back(e);
    endfunction

    // Expected access list of one XIP read whose status reads busy `busy` times.
    function automatic void push_xip(input logic [23:0] addr, input int busy);
        int reads;
        reads = (busy >= POLL_MAX) ? POLL_MAX : busy + 1;
        push_acc(1'b1, 5'h04, {8'h03, addr}, 4'hF);
        push_acc(1'b1, 5'h14, DIV_V, 4'hF);
        push_acc(1'b1, 5'h18, SS_V, 4'hF);
        push_acc(1'b1, 5'h10, 32'h0000_0140, 4'hF);
        for (int i = 0; i < reads; i++) push_acc(1'b0, 5'h10, 32'h0, 4'h0);
        if (busy < POLL_MAX) push_acc(1'b0, 5'h00, 32'h0, 4'h0);
        push_acc(1'b1, 5'h18, 32'h0, 4'hF);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] rx);
`ifdef SPI_XIP_BSWAP_EN
        return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
`else
        return rx;
`endif
    endfunction

    // Index of first divergence between logged and expected accesses, -1 if none.
    function automatic int first_diff();
        int n;
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (log_q[i] !== exp_q[i]) return i;
        if (log_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [4:0] rand_cpu_adr();
        logic [4:0] a;
        a = 5'($urandom_range(31, 1));
        if (a == 5'h10) a = 5'h11;
        return a;
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        xip_req = 1'b0;
        cpu_stb = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic xip_txn(input logic [23:0] addr, output logic to, output logic [31:0] rd,
                           output logic err, output longint t_ack, output logic ack2);
        @(negedge clock);
        xip_req  = 1'b1;
        xip_addr = addr;
        to = 1'b1; rd = 32'h0; err = 1'b0; t_ack = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (xip_ack) begin
                to = 1'b0; rd = xip_rdata; err = xip_err; t_ack = longint'($time);
                break;
            end
        end
        xip_req = 1'b0;
        @(negedge clock);
        ack2 = xip_ack;
    endtask

    task automatic cpu_txn(input logic we, input logic [4:0] adr, input logic [31:0] wd,
                           input logic [3:0] sel, output logic to, output logic [31:0] rd,
                           output longint t_ack, output logic ack2);
        @(negedge clock);
        cpu_stb = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wd; cpu_sel = sel;
        to = 1'b1; rd = 32'h0; t_ack = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (cpu_ack) begin
                to = 1'b0; rd = cpu_rdata; t_ack = longint'($time);
                break;
            end
        end
        cpu_stb = 1'b0;
        @(negedge clock);
        ack2 = cpu_ack;
    endtask

    task automatic test_reset();
        logic [109:0] v;
        repeat (2) @(negedge clock);
        v = {m_stb, m_we, m_adr, m_wdata, m_sel, xip_ack, xip_err, xip_rdata, cpu_ack, cpu_rdata};
        n_checks++;
        if (v !== 110'd0) $display("FAIL reset_outputs: got %h, want 0", v);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        v = {m_stb, m_we, m_adr, m_wdata, m_sel, xip_ack, xip_err, xip_rdata, cpu_ack, cpu_rdata};
        n_checks++;
        if (v !== 110'd0) $display("FAIL idle_outputs: got %h, want 0", v);
        else n_pass++;
    endtask

    task automatic test_xip_basic();
        logic to, err, a2; logic [31:0] rd; longint t; int d;
        lat_max = 0; poll_left = 2; rx_val = 32'h1122_3344;
        log_q.delete(); exp_q.delete();
        push_xip(24'h000010, 2);
        xip_txn(24'h000010, to, rd, err, t, a2);
        n_checks++;
        if (to !== 1'b0) $display("FAIL basic_timeout: got %b, want 0", to); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d !== -1) $display("FAIL basic_seq: divergence at %0d (logged %0d, want %0d)", d, log_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (rd !== exp_rdata(32'h1122_3344)) $display("FAIL basic_rdata: got %h, want %h", rd, exp_rdata(32'h1122_3344));
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL basic_err: got %b, want 0", err); else n_pass++;
        n_checks++;
        if (a2 !== 1'b0) $display("FAIL basic_ack_pulse: got %b, want 0", a2); else n_pass++;
    endtask

    task automatic test_tie();
        logic tx, tc, err, ax, ac; logic [31:0] rx, rc, wd; longint t_x, t_c;
        logic [4:0] adr; logic [3:0] sel; logic we; int d;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            lat_max = 1; poll_left = k; rx_val = $urandom;
            adr = rand_cpu_adr(); we = 1'($urandom); wd = $urandom; sel = 4'($urandom);
            log_q.delete(); exp_q.delete();
            push_xip(24'h00A000 + 24'(k), k);
            push_acc(we, adr, wd, sel);
            fork
                xip_txn(24'h00A000 + 24'(k), tx, rx, err, t_x, ax);
                cpu_txn(we, adr, wd, sel, tc, rc, t_c, ac);
            join
            n_checks++;
            if (tx !== 1'b0 || tc !== 1'b0) $display("FAIL tie%0d_timeout: got %b%b, want 00", k, tx, tc);
            else n_pass++;
            n_checks++;
            if (!(t_x < t_c)) $display("FAIL tie%0d_order: got xip ack %0d cpu ack %0d, want xip first", k, t_x, t_c);
            else n_pass++;
            d = first_diff();
            n_checks++;
            if (d !== -1) $display("FAIL tie%0d_seq: divergence at %0d (logged %0d, want %0d)", k, d, log_q.size(), exp_q.size());
            else n_pass++;
            n_checks++;
            if (rc !== regs[adr]) $display("FAIL tie%0d_cpu_rdata: got %h, want %h", k, rc, regs[adr]);
            else n_pass++;
        end
    endtask

    task automatic test_cpu_random();
        logic to, a2, we; logic [31:0] rd, wd, xhold; logic [4:0] adr; logic [3:0] sel;
        longint t; int d;
        xhold = xip_rdata;
        for (int k = 0; k < 6; k++) begin
            lat_max = k % 3;
            adr = rand_cpu_adr(); we = 1'($urandom); wd = $urandom; sel = 4'($urandom);
            log_q.delete(); exp_q.delete();
            push_acc(we, adr, wd, sel);
            cpu_txn(we, adr, wd, sel, to, rd, t, a2);
            d = first_diff();
            n_checks++;
            if (to !== 1'b0 || d !== -1) $display("FAIL cpu%0d_access: got timeout %b divergence %0d, want 0 and -1", k, to, d);
            else n_pass++;
            n_checks++;
            if (rd !== regs[adr]) $display("FAIL cpu%0d_rdata: got %h, want %h", k, rd, regs[adr]);
            else n_pass++;
            repeat (3) @(negedge clock);
            n_checks++;
            if (cpu_rdata !== regs[adr] || a2 !== 1'b0) $display("FAIL cpu%0d_hold: got %h ack %b, want %h ack 0", k, cpu_rdata, a2, regs[adr]);
            else n_pass++;
        end
        n_checks++;
        if (xip_rdata !== xhold) $display("FAIL xip_rdata_hold: got %h, want %h", xip_rdata, xhold);
        else n_pass++;
    endtask

    task automatic test_xip_random();
        logic to, err, a2; logic [31:0] rd, rxv; logic [23:0] addr; longint t; int busy, d;
        for (int k = 0; k < 6; k++) begin
            lat_max = int'($urandom_range(3, 0));
            busy = int'($urandom_range(6, 0));
            addr = 24'($urandom); rxv = $urandom;
            poll_left = busy; rx_val = rxv;
            log_q.delete(); exp_q.delete();
            push_xip(addr, busy);
            xip_txn(addr, to, rd, err, t, a2);
            d = first_diff();
            n_checks++;
            if (to !== 1'b0 || d !== -1) $display("FAIL xip%0d_seq: got timeout %b divergence %0d, want 0 and -1", k, to, d);
            else n_pass++;
            n_checks++;
            if (err !== (busy >= POLL_MAX)) $display("FAIL xip%0d_err: got %b, want %b", k, err, busy >= POLL_MAX);
            else n_pass++;
            if (busy < POLL_MAX) begin
                n_checks++;
                if (rd !== exp_rdata(rxv)) $display("FAIL xip%0d_rdata: got %h, want %h", k, rd, exp_rdata(rxv));
                else n_pass++;
            end
        end
    endtask

    task automatic test_cpu_during_poll();
        logic seen, got; logic [4:0] adr; logic [31:0] wd; int d, k;
        lat_max = 1; poll_left = 3; rx_val = 32'hCAFE_0001;
        adr = rand_cpu_adr(); wd = $urandom;
        log_q.delete(); exp_q.delete();
        push_xip(24'h123456, 3);
        @(negedge clock);
        xip_req = 1'b1; xip_addr = 24'h123456;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (m_stb && !m_we && m_adr == 5'h10) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (seen !== 1'b1) $display("FAIL poll_reached: got %b, want 1", seen); else n_pass++;
        cpu_stb = 1'b1; cpu_we = 1'b1; cpu_adr = adr; cpu_wdata = wd; cpu_sel = 4'hF;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (xip_ack) begin got = 1'b1; break; end
        end
        xip_req = 1'b0;
        d = first_diff();
        n_checks++;
        if (got !== 1'b1 || d !== -1) $display("FAIL poll_atomic: got ack %b divergence %0d, want 1 and -1", got, d);
        else n_pass++;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            k++;
            if (m_stb) break;
        end
        n_checks++;
        if (k > 2) $display("FAIL cpu_after_done: got %0d cycles, want <= 2", k); else n_pass++;
        push_acc(1'b1, adr, wd, 4'hF);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cpu_ack) begin got = 1'b1; break; end
            @(negedge clock);
        end
        cpu_stb = 1'b0;
        d = first_diff();
        n_checks++;
        if (got !== 1'b1 || d !== -1) $display("FAIL cpu_after_seq: got ack %b divergence %0d, want 1 and -1", got, d);
        else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_timeout();
        logic to, err, a2; logic [31:0] rd; longint t; int d;
        lat_max = 2; poll_left = 1000; rx_val = 32'h0;
        log_q.delete(); exp_q.delete();
        push_xip(24'hFFFFFF, 1000);
        xip_txn(24'hFFFFFF, to, rd, err, t, a2);
        poll_left = 0;
        d = first_diff();
        n_checks++;
        if (to !== 1'b0 || d !== -1) $display("FAIL timeout_seq: got timeout %b divergence %0d, want 0 and -1", to, d);
        else n_pass++;
        n_checks++;
        if (err !== 1'b1) $display("FAIL timeout_err: got %b, want 1", err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic seen, to, err, a2; logic [31:0] rd; longint t; int d; logic [109:0] v;
        lat_max = 3; poll_left = 0; rx_val = 32'h5566_7788;
        @(negedge clock);
        xip_req = 1'b1; xip_addr = 24'h000100;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (m_stb && m_we && m_adr == 5'h10) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (seen !== 1'b1) $display("FAIL go_reached: got %b, want 1", seen); else n_pass++;
        #1;
        reset = 1'b1;
        xip_req = 1'b0;
        #1;
        v = {m_stb, m_we, m_adr, m_wdata, m_sel, xip_ack, xip_err, xip_rdata, cpu_ack, cpu_rdata};
        n_checks++;
        if (v !== 110'd0) $display("FAIL async_reset: got %h, want 0", v); else n_pass++;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        log_q.delete(); exp_q.delete();
        push_xip(24'h000200, 0);
        xip_txn(24'h000200, to, rd, err, t, a2);
        d = first_diff();
        n_checks++;
        if (to !== 1'b0 || d !== -1) $display("FAIL restart_seq: got timeout %b divergence %0d, want 0 and -1", to, d);
        else n_pass++;
        n_checks++;
        if (rd !== exp_rdata(32'h5566_7788)) $display("FAIL restart_rdata: got %h, want %h", rd, exp_rdata(32'h5566_7788));
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        test_reset();
        test_xip_basic();
        test_tie();
        test_cpu_random();
        test_xip_random();
        test_cpu_during_poll();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
